// File: rtl/ripple_capture.sv
// Capture stage for a 4-bit ripple counter: synchronize, filter to stable, extend with a wrap
// count and hand out atomic {ext, cur} snapshots. Optional macro: RIPPLE_CAPTURE_SATURATE_EN.
module ripple_capture #(
    parameter int EXT_W    = 8,
    parameter int STABLE_N = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         cnt_in,
    input  logic               clear,
    input  logic               snap_req,
    input  logic               snap_ready,
    output logic               snap_valid,
    output logic [EXT_W+3:0]   snap_data,
    output logic               wrap_pulse,
    output logic               stable
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_N);

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    logic [3:0]       r_s1, r_s2, r_run, r_cur;
    logic [EXT_W-1:0] r_ext;
    logic             r_wrap, r_stable;
    logic [EXT_W+3:0] r_snap_data;
    state_t           r_state;

    logic             w_match, w_accept, w_wrap, w_snap_load;
    logic [4:0]       w_run_inc;
    logic [3:0]       w_run_nxt;
    logic [EXT_W-1:0] w_ext_inc, w_ext_nxt;
    state_t           w_state_nxt;

    // Acceptance fires once per stable run: only on the edge where run first reaches STABLE_N.
    always_comb begin
        w_match   = (r_s1 == r_s2);
        w_run_inc = {1'b0, r_run} + 5'd1;
        w_accept  = w_match && (w_run_inc == {1'b0, RUN_MAX});
        w_run_nxt = 4'd0;
        if (w_match)
            w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : w_run_inc[3:0];
        w_wrap    = w_accept && (r_s2 < r_cur);
    end

    always_comb begin
`ifdef RIPPLE_CAPTURE_SATURATE_EN
        w_ext_inc = (&r_ext) ? r_ext : r_ext + 1'b1;
`else
        w_ext_inc = r_ext + 1'b1;
`endif
        w_ext_nxt = r_ext;
        if (clear)
            w_ext_nxt = '0;
        else if (w_wrap)
            w_ext_nxt = w_ext_inc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1     <= 4'd0;
            r_s2     <= 4'd0;
            r_run    <= 4'd0;
            r_cur    <= 4'd0;
            r_ext    <= '0;
            r_wrap   <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_s1     <= cnt_in;
            r_s2     <= r_s1;
            r_run    <= w_run_nxt;
            r_stable <= (w_run_nxt == RUN_MAX);
            r_wrap   <= w_wrap;
            r_ext    <= w_ext_nxt;
            if (w_accept)
                r_cur <= r_s2;
        end
    end

    // Snapshot FSM: state register, next-state, outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (snap_req)   w_state_nxt = S_HOLD;
            S_HOLD:  if (snap_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_snap_load = (r_state == S_IDLE) && snap_req;
    end

    // Loads pre-update {ext, cur}, so a same-edge wrap lands in the next snapshot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_snap_data <= '0;
        else if (w_snap_load)
            r_snap_data <= {r_ext, r_cur};
    end

    assign snap_valid = (r_state == S_HOLD);
    assign snap_data  = r_snap_data;
    assign wrap_pulse = r_wrap;
    assign stable     = r_stable;

endmodule

// File: tb/tb_ripple_capture.sv
// Directed bench for ripple_capture (EXT_W=8, STABLE_N=2); snapshot values go through a scoreboard queue.
module tb_ripple_capture;

    logic        clock, reset, clear, snap_req, snap_ready;
    logic [3:0]  cnt_in;
    logic        snap_valid, wrap_pulse, stable;
    logic [11:0] snap_data;

    int n_cmp = 0;
    int n_err = 0;
    int wrap_cnt = 0;
    int wc0;
    logic [11:0] exp_q[$];

    ripple_capture #(.EXT_W(8), .STABLE_N(2)) dut (
        .clock(clock), .reset(reset), .cnt_in(cnt_in), .clear(clear),
        .snap_req(snap_req), .snap_ready(snap_ready), .snap_valid(snap_valid),
        .snap_data(snap_data), .wrap_pulse(wrap_pulse), .stable(stable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (wrap_pulse === 1'b1) wrap_cnt <= wrap_cnt + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        cnt_in = v;
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed snapshot %0h expected none queued", tag, snap_data);
        end else begin
            chk(tag, {20'd0, snap_data}, {20'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_reset(input logic [3:0] v);
        cnt_in = v;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    task automatic snap(input string tag, input logic [11:0] e);
        exp_q.push_back(e);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk({tag, "_vld"}, {31'd0, snap_valid}, 32'd1);
        sb_pop(tag);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        chk({tag, "_drop"}, {31'd0, snap_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; cnt_in = 4'hA; clear = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
        #22;
        chk("rst_valid",  {31'd0, snap_valid}, 32'd0);
        chk("rst_data",   {20'd0, snap_data},  32'd0);
        chk("rst_wrap",   {31'd0, wrap_pulse}, 32'd0);
        chk("rst_stable", {31'd0, stable},     32'd0);

        // Release with 4'hA held: accepted on edge 4, no wrap.
        @(posedge clock); #1;
        reset = 1'b0;
        wc0 = wrap_cnt;
        repeat (3) tick();
        chk("rst_e3_stable", {31'd0, stable}, 32'd0);
        tick();
        chk("rst_e4_stable", {31'd0, stable}, 32'd1);
        repeat (2) tick();
        chk("rst_nowrap", wrap_cnt - wc0, 32'd0);
        snap("snap_A", 12'h00A);

        // Step 0..15 then 3: single wrap on the 15->3 acceptance.
        do_reset(4'h0);
        hold(4'h0, 6);
        wc0 = wrap_cnt;
        for (int v = 1; v < 16; v++) hold(v[3:0], 6);
        chk("step_nowrap", wrap_cnt - wc0, 32'd0);
        cnt_in = 4'h3;
        repeat (3) tick();
        chk("step_e3_pulse", {31'd0, wrap_pulse}, 32'd0);
        tick();
        chk("step_e4_pulse", {31'd0, wrap_pulse}, 32'd1);
        tick();
        chk("step_e5_pulse", {31'd0, wrap_pulse}, 32'd0);
        repeat (2) tick();
        chk("step_wrapcnt", wrap_cnt - wc0, 32'd1);
        snap("snap_013", 12'h013);

        // Alternate 6/5 every cycle with a snapshot taken in the middle.
        wc0 = wrap_cnt;
        for (int i = 0; i < 20; i++) begin
            cnt_in   = (i % 2 == 0) ? 4'h6 : 4'h5;
            snap_req = (i == 10);
            if (i == 10) exp_q.push_back(12'h013);
            tick();
        end
        snap_req = 1'b0;
        chk("alt_stable", {31'd0, stable}, 32'd0);
        chk("alt_valid", {31'd0, snap_valid}, 32'd1);
        sb_pop("alt_snap");
        cnt_in = 4'h6;
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        chk("alt_drop", {31'd0, snap_valid}, 32'd0);
        repeat (2) tick();
        chk("alt_e3_stable", {31'd0, stable}, 32'd0);
        tick();
        chk("alt_e4_stable", {31'd0, stable}, 32'd1);
        repeat (2) tick();
        chk("alt_nowrap", wrap_cnt - wc0, 32'd0);
        snap("snap_016", 12'h016);

        // Snapshot held with ready low across a wrap; repeated requests ignored.
        exp_q.push_back(12'h016);
        snap_req = 1'b1;
        cnt_in   = 4'h2;
        tick();
        chk("hold_e1_valid", {31'd0, snap_valid}, 32'd1);
        repeat (3) tick();
        chk("hold_e4_pulse", {31'd0, wrap_pulse}, 32'd1);
        sb_pop("hold_frozen");
        tick();
        chk("hold_e5_valid", {31'd0, snap_valid}, 32'd1);
        chk("hold_e5_data", {20'd0, snap_data}, 32'h016);
        snap_req   = 1'b0;
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        chk("hold_release", {31'd0, snap_valid}, 32'd0);
        snap("snap_022", 12'h022);

        // Five more wraps to ext=7, then clear coincident with a wrap.
        for (int k = 0; k < 5; k++) begin
            hold(4'hA, 6);
            hold(4'h1, 6);
        end
        hold(4'h9, 6);
        snap("snap_079", 12'h079);
        cnt_in = 4'h0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_pulse", {31'd0, wrap_pulse}, 32'd1);
        tick();
        snap("snap_clr", 12'h000);

        // 255 then 256 wraps: boundary of the extension field.
        wc0 = wrap_cnt;
        for (int k = 0; k < 255; k++) begin
            hold(4'h8, 6);
            hold(4'h0, 6);
        end
        snap("snap_255", 12'hFF0);
        hold(4'h8, 6);
        hold(4'h0, 6);
`ifdef RIPPLE_CAPTURE_SATURATE_EN
        snap("snap_256", 12'hFF0);
`else
        snap("snap_256", 12'h000);
`endif
        chk("wraps_256", wrap_cnt - wc0, 32'd256);

        // Reset mid-HOLD clears outputs without waiting for an edge.
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("midhold_valid", {31'd0, snap_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid",  {31'd0, snap_valid}, 32'd0);
        chk("arst_data",   {20'd0, snap_data},  32'd0);
        chk("arst_stable", {31'd0, stable},     32'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ripple_capture.md
# ripple_capture

Synchronous capture stage placed directly downstream of the 4-bit JK ripple counter. It samples the counter's asynchronous, glitch-prone `q[3:0]` into the `clock` domain and filters it until stable. It extends the count with a wrap-tracking upper field and hands out atomic snapshots over a valid/ready handshake. Consumers read the ripple counter only through this block.

## Interface
- `EXT_W`, default 8: width of the wrap-extension field, in the range 1..24.
- `STABLE_N`, default 2: number of consecutive matching synchronized samples required to accept a value, in the range 1..15.

- `clock`  in  1  rising-edge system clock.
- `reset`  in  1  asynchronous, active-high reset; clears all state.
- `cnt_in`  in  4  ripple counter `q[3:0]`; asynchronous to `clock`.
- `clear`  in  1  synchronous clear of the extension field.
- `snap_req`  in  1  request a snapshot; sampled only in IDLE.
- `snap_ready`  in  1  consumer accepts the snapshot.
- `snap_valid`  out  1  snapshot available.
- `snap_data`  out  EXT_W+4  snapshot `{ext, cur}`.
- `wrap_pulse`  out  1  one-cycle pulse on a detected wrap.
- `stable`  out  1  filter currently satisfied.

## Operation
- Synchronizer: two flops, `s1 <= cnt_in` and `s2 <= s1`.
- Filter:
  - `run` is a saturating counter, 0..STABLE_N.
  - `run <= (s1==s2) ? min(run+1, STABLE_N) : 0`.
  - When `run+1` reaches STABLE_N on a match edge, `cur <= s2`.
  - `stable <= (next run == STABLE_N)`.
- Wrap: on an acceptance edge where `s2 < cur`:
  - `ext <= ext+1`, modulo 2^EXT_W.
  - `wrap_pulse <= 1` for exactly one cycle.
  - At most one wrap is counted per acceptance. The upstream counter must advance fewer than 16 counts between acceptances.
  - Accepting an equal or larger value only updates `cur`.
- Clear: `ext <= 0` on the edge. `clear` wins over a simultaneous wrap increment, but `wrap_pulse` still fires. `cur` is unaffected.
- Snapshot FSM, two states:
  - IDLE: on `snap_req`, `snap_data <= {ext, cur}`. These are the register values before any update on that same edge. Then `snap_valid <= 1` and the FSM goes to HOLD.
  - HOLD: `snap_valid` stays 1 and `snap_data` stays frozen. `snap_req` is ignored. On `snap_valid && snap_ready`, set `snap_valid <= 0` and return to IDLE. A new request is served one cycle later at the earliest.
  - `snap_ready` in IDLE has no effect.
- Reset: every output and internal register goes to 0 and the FSM to IDLE. Reset mid-HOLD drops the pending snapshot immediately.

## Timing
- `cnt_in` settled and held before edge 1: `s2` is new at edge 2 and `cur` updates at edge STABLE_N+2. For STABLE_N=2 that is edge 4.
- `wrap_pulse`, the `ext` update and the `cur` update occur on the same edge.
- `snap_valid` rises one edge after `snap_req` is sampled in IDLE.
- Minimum snapshot turnaround is 2 cycles, with `snap_ready` tied high.
- `cnt_in` toggling every cycle keeps `run` at 0, leaves `cur` held and keeps `stable` at 0.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `RIPPLE_CAPTURE_SATURATE_EN`:
  - Defined: `ext` saturates at all-ones. Further wraps still pulse `wrap_pulse` but do not change `ext`.
  - Undefined: `ext` wraps modulo 2^EXT_W, so all-ones + 1 gives 0.

## Test plan
- Reset with `cnt_in`=4'hA: all outputs are 0 while reset is high. After release with the input held, `cur`=4'hA at edge 4 and `stable`=1. `wrap_pulse` stays 0 because 0 < 10 is not a wrap.
- Step `cnt_in` through 0..15 and then 3, each held 6 cycles: exactly one `wrap_pulse`, on the 15→3 acceptance. Snapshot then returns `snap_data`=12'h013 (EXT_W=8).
- `cnt_in` alternates 5/6 every cycle for 20 cycles: `cur` is unchanged, `stable`=0 and there is no pulse. Then hold 6: `cur`=6 at edge 4.
- `snap_req` pulse with `snap_ready` low for 5 cycles while a wrap occurs: `snap_data` stays frozen at its pre-wrap value and `snap_valid` stays 1. Release with `snap_ready`=1: `snap_valid` drops the next edge.
- `clear` on the same edge as a wrap with `ext`=7: `ext`=0 and `wrap_pulse`=1.
- 256 wraps with EXT_W=8: `ext`=0 without the macro and 8'hFF with `RIPPLE_CAPTURE_SATURATE_EN`. Reset asserted mid-HOLD clears `snap_valid` asynchronously.
